stack_arbiter: RTL and testbench
================================

Name: stack_arbiter

Overview:
Shares one LIFO stack (storage, pointer and full/empty tracking are inside this block) between two requesters. Each requester issues push or pop operations over a req/gnt handshake. A round-robin arbiter services at most one operation per clock. Pop data returns one cycle later, tagged with the requester ID. Sits between two datapath clients and the stack storage, replacing direct push/pop wiring.

Parameters:
WIDTH, 11, data word width in bits
DEPTH, 7, pointer width; capacity = 2**DEPTH entries

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req0  input  1  requester 0 operation request; held until granted
op0  input  1  requester 0 opcode: 1=push, 0=pop
d0  input  WIDTH  requester 0 push data
req1  input  1  requester 1 operation request
op1  input  1  requester 1 opcode: 1=push, 0=pop
d1  input  WIDTH  requester 1 push data
gnt0  output  1  combinational grant to requester 0
gnt1  output  1  combinational grant to requester 1
q  output  WIDTH  pop result, registered
q_valid  output  1  one-cycle pulse: q holds a valid pop result
q_id  output  1  requester that issued the pop reported by q_valid
count  output  DEPTH+1  current occupancy, 0..2**DEPTH
full  output  1  count == 2**DEPTH
empty  output  1  count == 0
err  output  1  one-cycle pulse: overflow push or underflow pop

Behaviour:
- Reset (reset=1 at rising edge): count=0, q=0, q_valid=0, q_id=0, err=0, rr_ptr=0. Storage contents are not cleared. gnt0 and gnt1 are forced to 0 while reset=1. Requests present during reset are ignored, not queued.
- Arbitration (combinational):
  - Only one requester active: it is granted.
  - Both active: grant the requester selected by rr_ptr (0 selects req0).
  - gnt0 and gnt1 are never both 1.
- Handshake: an operation executes at the rising edge where req_i and gnt_i are both 1. The requester may change op/d or drop req after that edge. The requester must hold op_i and d_i stable while req_i=1 and ungranted.
- rr_ptr update: after executing a grant to requester i, rr_ptr is set to the other requester. rr_ptr is unchanged in cycles with no grant.
- Push, not full: store d at mem[count[DEPTH-1:0]]; count+1.
- Push, full: no write; count unchanged; err=1 next cycle. The grant is still consumed.
- Pop, not empty: q=mem[count-1], q_valid=1, q_id=granted index, all on the next cycle; count-1.
- Pop, empty: count unchanged; q holds its previous value; q_valid=0; err=1 next cycle. The grant is still consumed.
- q_valid and err are single-cycle pulses. q keeps its last valid value between pops.
- count never wraps. full and empty are decoded combinationally from count. count width is DEPTH+1 so that 2**DEPTH is representable.
- Throughput: one operation per cycle sustained. Back-to-back push then pop returns the just-pushed word.
- Latency: pop result appears 1 cycle after the granting edge.

Test Plan:
- Reset then idle -> count=0, empty=1, full=0, q=0, q_valid=0, gnt0=gnt1=0. Assert reset=1 with req0=1 -> gnt0=0 and count stays 0.
- req0 push 0x055, then req0 push 0x123, then req0 pop -> count 1, 2, 1. Pop gives q=0x123, q_valid=1, q_id=0 one cycle after the grant.
- req0 and req1 both held high, pushing 0x001 and 0x002 -> gnt0 first (rr_ptr=0), gnt1 next cycle. Then req0 and req1 pop together -> grant order continues alternating. Pops return 0x002 then 0x001, with q_id matching each granted requester.
- Pop on empty from req1 -> gnt1=1, err=1 next cycle, q_valid=0, count=0, q unchanged.
- With DEPTH=3, push 8 words 0x010..0x017 -> full=1, count=8. Push 0x0FF -> err=1, count=8. Pop -> q=0x017, not 0x0FF.
- Fill count to 3, assert reset mid-stream while req1 pops -> next cycle count=0, q_valid=0, rr_ptr=0. A subsequent pop on req0 flags err.

Source files
------------

// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin shared LIFO stack for two push/pop requesters
module stack_arbiter #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             op0,
  input  logic [WIDTH-1:0] d0,
  input  logic             req1,
  input  logic             op1,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             q_id,
  output logic [DEPTH:0]   count,
  output logic             full,
  output logic             empty,
  output logic             err
);
  localparam logic [DEPTH:0] cap = {1'b1, {DEPTH{1'b0}}};
  logic [WIDTH-1:0] mem [2**DEPTH];
  logic             rr_ptr;
  logic             any;
  logic             op;
  logic [WIDTH-1:0] d;
  logic [DEPTH-1:0] top;
  always_comb begin
    gnt0  = !reset && req0 && (!req1 || !rr_ptr);
    gnt1  = !reset && req1 && (!req0 || rr_ptr);
    any   = gnt0 || gnt1;
    op    = gnt1 ? op1 : op0;
    d     = gnt1 ? d1 : d0;
    full  = count == cap;
    empty = count == '0;
    top   = count[DEPTH-1:0] - 1'b1;
  end
  always_ff @(posedge clk)
    if (any && op && !full) mem[count[DEPTH-1:0]] <= d;
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      q_id    <= 1'b0;
      err     <= 1'b0;
      rr_ptr  <= 1'b0;
    end else begin
      q_valid <= 1'b0;
      err     <= 1'b0;
      if (any) begin
        rr_ptr <= gnt0;
        if (op) begin
          if (full) err <= 1'b1;
          else count <= count + 1'b1;
        end else if (empty) begin
          err <= 1'b1;
        end else begin
          q       <= mem[top];
          q_valid <= 1'b1;
          q_id    <= gnt1;
          count   <= count - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: directed self-checking bench for stack_arbiter
module tb_stack_arbiter;
  localparam int WIDTH = 11;
  localparam int DEPTH = 3;
  logic             clk = 1'b0;
  logic             reset;
  logic             req0, op0, req1, op1;
  logic [WIDTH-1:0] d0, d1;
  logic             gnt0, gnt1;
  logic [WIDTH-1:0] q;
  logic             q_valid, q_id;
  logic [DEPTH:0]   count;
  logic             full, empty, err;
  int               errors = 0;
  int               checks = 0;
  stack_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .op0(op0), .d0(d0),
    .req1(req1), .op1(op1), .d1(d1),
    .gnt0(gnt0), .gnt1(gnt1),
    .q(q), .q_valid(q_valid), .q_id(q_id),
    .count(count), .full(full), .empty(empty), .err(err)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 1'b1;
    req0 = 1'b0; op0 = 1'b0; d0 = '0;
    req1 = 1'b0; op1 = 1'b0; d1 = '0;
    tick; tick;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_q", 32'(q), 0);
    chk("rst_qv", 32'(q_valid), 0);
    chk("rst_gnt0", 32'(gnt0), 0);
    chk("rst_gnt1", 32'(gnt1), 0);
    req0 = 1'b1; op0 = 1'b1; d0 = 11'h055;
    #1 chk("rst_req_gnt0", 32'(gnt0), 0);
    tick;
    chk("rst_req_count", 32'(count), 0);
    reset = 1'b0;
    #1 chk("push1_gnt0", 32'(gnt0), 1);
    tick;
    chk("push1_count", 32'(count), 1);
    d0 = 11'h123;
    #1 chk("push2_gnt0", 32'(gnt0), 1);
    tick;
    chk("push2_count", 32'(count), 2);
    op0 = 1'b0;
    tick;
    chk("pop_count", 32'(count), 1);
    chk("pop_q", 32'(q), 11'h123);
    chk("pop_qv", 32'(q_valid), 1);
    chk("pop_qid", 32'(q_id), 0);
    req0 = 1'b0; req1 = 1'b1; op1 = 1'b0;
    #1 chk("pop1_gnt1", 32'(gnt1), 1);
    tick;
    chk("pop1_q", 32'(q), 11'h055);
    chk("pop1_qid", 32'(q_id), 1);
    chk("pop1_count", 32'(count), 0);
    req0 = 1'b1; op0 = 1'b1; d0 = 11'h001;
    req1 = 1'b1; op1 = 1'b1; d1 = 11'h002;
    #1 chk("both_push_gnt0", 32'(gnt0), 1);
    chk("both_push_gnt1", 32'(gnt1), 0);
    tick;
    chk("both_push_count1", 32'(count), 1);
    chk("both_push_gnt1_next", 32'(gnt1), 1);
    chk("both_push_gnt0_next", 32'(gnt0), 0);
    req0 = 1'b0;
    tick;
    chk("both_push_count2", 32'(count), 2);
    req0 = 1'b1; op0 = 1'b0; op1 = 1'b0;
    #1 chk("both_pop_gnt0", 32'(gnt0), 1);
    chk("both_pop_gnt1", 32'(gnt1), 0);
    tick;
    chk("both_pop_q_a", 32'(q), 11'h002);
    chk("both_pop_qid_a", 32'(q_id), 0);
    chk("both_pop_qv_a", 32'(q_valid), 1);
    chk("both_pop_gnt1_next", 32'(gnt1), 1);
    tick;
    chk("both_pop_q_b", 32'(q), 11'h001);
    chk("both_pop_qid_b", 32'(q_id), 1);
    chk("both_pop_count", 32'(count), 0);
    req0 = 1'b0; req1 = 1'b0;
    tick;
    chk("idle_qv", 32'(q_valid), 0);
    req1 = 1'b1; op1 = 1'b0;
    #1 chk("uf_gnt1", 32'(gnt1), 1);
    tick;
    chk("uf_err", 32'(err), 1);
    chk("uf_qv", 32'(q_valid), 0);
    chk("uf_count", 32'(count), 0);
    chk("uf_q", 32'(q), 11'h001);
    req1 = 1'b0;
    tick;
    chk("uf_err_pulse", 32'(err), 0);
    req0 = 1'b1; op0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d0 = 11'(11'h010 + i);
      tick;
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 8);
    chk("fill_err", 32'(err), 0);
    d0 = 11'h0FF;
    #1 chk("of_gnt0", 32'(gnt0), 1);
    tick;
    chk("of_err", 32'(err), 1);
    chk("of_count", 32'(count), 8);
    op0 = 1'b0;
    tick;
    chk("of_pop_q", 32'(q), 11'h017);
    chk("of_pop_qv", 32'(q_valid), 1);
    chk("of_pop_count", 32'(count), 7);
    chk("of_pop_full", 32'(full), 0);
    tick; tick; tick; tick;
    chk("mid_count", 32'(count), 3);
    chk("mid_q", 32'(q), 11'h013);
    req0 = 1'b0; req1 = 1'b1; op1 = 1'b0; reset = 1'b1;
    #1 chk("mid_rst_gnt1", 32'(gnt1), 0);
    tick;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_qv", 32'(q_valid), 0);
    reset = 1'b0; req0 = 1'b1; op0 = 1'b0;
    #1 chk("post_rst_gnt0", 32'(gnt0), 1);
    chk("post_rst_gnt1", 32'(gnt1), 0);
    tick;
    chk("post_rst_err", 32'(err), 1);
    chk("post_rst_count", 32'(count), 0);
    req0 = 1'b0; req1 = 1'b0;
    tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
